// File: rtl/nn_io_sequencer.sv
// nn_io_sequencer
//   Drives the 3-state data-path machine (IN / BUFF / OUT) from its registered
//   state output, and moves data between the 8-bit I/O pins and the neural core.
//   LOAD  : byte-serial input words are written into buf_data.
//   RUN   : the core is started and its result latched on core_done.
//   DRAIN : result words are streamed out, one per out_valid/out_ready handshake.
//   SYNC  : waits for the state machine to reach the expected state.
//   BUFF/OUT passes repeat N_LAYERS times before the machine returns to IN.
//
// Ports
//   clk, reset            clock, synchronous active-high reset
//   state                 registered state of the data-path machine
//   in_valid/in_data      input word stream; in_ready accepts
//   buf_data              input buffer, word k at [8k+7:8k]
//   core_start/core_done  core start pulse / result-valid pulse
//   res_data              core results, sampled on core_done
//   out_valid/out_data    result word stream; out_ready takes
//   changes/finished      one-cycle pulses to the data-path machine
//   layer_idx             current layer
module nn_io_sequencer #(
   parameter int unsigned N_IN     = 4,
   parameter int unsigned N_OUT    = 2,
   parameter int unsigned N_LAYERS = 2,
   localparam int unsigned LayerW  = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             state,
   input  logic                   in_valid,
   input  logic [7:0]             in_data,
   output logic                   in_ready,
   output logic [8*N_IN-1:0]      buf_data,
   output logic                   core_start,
   input  logic                   core_done,
   input  logic [8*N_OUT-1:0]     res_data,
   output logic                   out_valid,
   output logic [7:0]             out_data,
   input  logic                   out_ready,
   output logic                   changes,
   output logic                   finished,
   output logic [LayerW-1:0]      layer_idx
);

   localparam int unsigned WrPtrW = (N_IN > 1) ? $clog2(N_IN) : 1;
   localparam int unsigned RdPtrW = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   localparam logic [WrPtrW-1:0] WrLast    = WrPtrW'(N_IN - 1);
   localparam logic [RdPtrW-1:0] RdLast    = RdPtrW'(N_OUT - 1);
   localparam logic [LayerW-1:0] LayerLast = LayerW'(N_LAYERS - 1);

   // Encodings of the data-path machine's state register
   localparam logic [1:0] SmIn   = 2'b00;
   localparam logic [1:0] SmBuff = 2'b01;
   localparam logic [1:0] SmOut  = 2'b10;

   typedef enum logic [1:0] {StLoad, StRun, StDrain, StSync} seq_state_e;

   seq_state_e        fsm_q;
   logic [1:0]        exp_state_q;
   logic [WrPtrW-1:0] wr_ptr_q;
   logic [RdPtrW-1:0] rd_ptr_q;
   logic [7:0]        buf_q [N_IN];
   logic [7:0]        res_q [N_OUT];

   always_comb begin
      buf_data = '0;
      for (int k = 0; k < N_IN; k++) begin
         buf_data[8*k +: 8] = buf_q[k];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm_q       <= StSync;
         exp_state_q <= SmIn;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         in_ready    <= 1'b0;
         core_start  <= 1'b0;
         out_valid   <= 1'b0;
         out_data    <= '0;
         changes     <= 1'b0;
         finished    <= 1'b0;
         layer_idx   <= '0;
         for (int k = 0; k < N_IN; k++) buf_q[k] <= '0;
         for (int k = 0; k < N_OUT; k++) res_q[k] <= '0;
      end else begin
         // Pulses last exactly one cycle
         changes    <= 1'b0;
         finished   <= 1'b0;
         core_start <= 1'b0;

         unique case (fsm_q)
            StSync: begin
               // Outputs are registered, so enabling them here makes the first
               // action land the cycle after the expected state is seen.
               if (state == exp_state_q) begin
                  case (exp_state_q)
                     SmIn: begin
                        fsm_q    <= StLoad;
                        in_ready <= 1'b1;
                     end
                     SmBuff: begin
                        fsm_q      <= StRun;
                        core_start <= 1'b1;
                     end
                     SmOut: begin
                        fsm_q     <= StDrain;
                        out_valid <= 1'b1;
                        out_data  <= res_q[0];
                     end
                     default: fsm_q <= StSync;
                  endcase
               end
            end

            StLoad: begin
               if (in_valid && in_ready) begin
                  buf_q[wr_ptr_q] <= in_data;
                  if (wr_ptr_q == WrLast) begin
                     wr_ptr_q    <= '0;
                     in_ready    <= 1'b0;
                     changes     <= 1'b1;
                     exp_state_q <= SmBuff;
                     fsm_q       <= StSync;
                  end else begin
                     wr_ptr_q <= wr_ptr_q + 1'b1;
                  end
               end
            end

            StRun: begin
               // A done coinciding with our own start pulse is stale
               if (core_done && !core_start) begin
                  for (int k = 0; k < N_OUT; k++) res_q[k] <= res_data[8*k +: 8];
                  changes     <= 1'b1;
                  exp_state_q <= SmOut;
                  fsm_q       <= StSync;
               end
            end

            StDrain: begin
               if (out_valid && out_ready) begin
                  if (rd_ptr_q == RdLast) begin
                     rd_ptr_q  <= '0;
                     out_valid <= 1'b0;
                     fsm_q     <= StSync;
                     if (layer_idx == LayerLast) begin
                        layer_idx   <= '0;
                        finished    <= 1'b1;
                        exp_state_q <= SmIn;
                     end else begin
                        layer_idx   <= layer_idx + 1'b1;
                        changes     <= 1'b1;
                        exp_state_q <= SmBuff;
                     end
                  end else begin
                     rd_ptr_q <= rd_ptr_q + 1'b1;
                     out_data <= res_q[rd_ptr_q + 1'b1];
                  end
               end
            end

            default: fsm_q <= StSync;
         endcase
      end
   end

endmodule

// File: tb/tb_nn_io_sequencer.sv
module tb_nn_io_sequencer;

   logic        clk;
   logic        reset;
   logic [1:0]  state;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic [31:0] buf_data;
   logic        core_start;
   logic        core_done;
   logic [15:0] res_data;
   logic        out_valid;
   logic [7:0]  out_data;
   logic        out_ready;
   logic        changes;
   logic        finished;
   logic [0:0]  layer_idx;

   int n_tests = 0;
   int n_fail  = 0;

   nn_io_sequencer #(
      .N_IN     (4),
      .N_OUT    (2),
      .N_LAYERS (2)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .state      (state),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .buf_data   (buf_data),
      .core_start (core_start),
      .core_done  (core_done),
      .res_data   (res_data),
      .out_valid  (out_valid),
      .out_data   (out_data),
      .out_ready  (out_ready),
      .changes    (changes),
      .finished   (finished),
      .layer_idx  (layer_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Data-path state machine model: pulse at t, state visible at t+2
   logic [1:0] sm_int;
   always @(posedge clk) begin
      if (reset) begin
         sm_int <= 2'b00;
         state  <= 2'b00;
      end else begin
         if (finished)     sm_int <= 2'b00;
         else if (changes) sm_int <= (sm_int == 2'b01) ? 2'b10 : 2'b01;
         state <= sm_int;
      end
   end

   // Pulse monitor
   int   n_chg = 0, n_fin = 0, n_both = 0, n_long = 0;
   logic chg_prev = 1'b0, fin_prev = 1'b0;
   always @(negedge clk) begin
      if (changes === 1'b1) n_chg++;
      if (finished === 1'b1) n_fin++;
      if (changes === 1'b1 && finished === 1'b1) n_both++;
      if ((changes === 1'b1 && chg_prev) || (finished === 1'b1 && fin_prev)) n_long++;
      chg_prev = (changes === 1'b1);
      fin_prev = (finished === 1'b1);
   end

   int chg_base, fin_base;
   logic [7:0] vals [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

   task automatic test_reset;
      repeat (3) @(negedge clk);
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
      n_tests++; if ({core_start, out_valid, changes, finished} !== 4'b0) begin
         n_fail++; $display("FAIL rst_pulses got %b want 0000", {core_start, out_valid, changes, finished}); end
      n_tests++; if (out_data !== 8'h00) begin n_fail++; $display("FAIL rst_out_data got %h want 00", out_data); end
      n_tests++; if (buf_data !== 32'h0) begin n_fail++; $display("FAIL rst_buf got %h want 0", buf_data); end
      n_tests++; if (layer_idx !== 1'b0) begin n_fail++; $display("FAIL rst_layer got %b want 0", layer_idx); end
      reset = 1'b0;
      @(negedge clk);
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_exit_ready got %b want 1", in_ready); end
      n_tests++; if (changes !== 1'b0) begin n_fail++; $display("FAIL rst_exit_chg got %b want 0", changes); end
   endtask

   task automatic test_reset_mid_load;
      int base;
      base = n_chg;
      in_valid = 1'b1; in_data = 8'hA1; @(negedge clk);
      in_data = 8'hA2; @(negedge clk);
      in_valid = 1'b0;
      n_tests++; if (buf_data !== 32'h0000A2A1) begin n_fail++; $display("FAIL mid_partial got %h want 0000a2a1", buf_data); end
      reset = 1'b1; @(negedge clk);
      n_tests++; if (buf_data !== 32'h0) begin n_fail++; $display("FAIL mid_buf_clr got %h want 0", buf_data); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready got %b want 0", in_ready); end
      reset = 1'b0; @(negedge clk);
      n_tests++; if (changes !== 1'b0) begin n_fail++; $display("FAIL mid_chg got %b want 0", changes); end
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_reload_ready got %b want 1", in_ready); end
      n_tests++; if (n_chg !== base) begin n_fail++; $display("FAIL mid_no_pulse got %0d want %0d", n_chg, base); end
   endtask

   task automatic test_load;
      chg_base = n_chg;
      fin_base = n_fin;
      core_done = 1'b1; res_data = 16'hDEAD;  // spurious done during LOAD
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = vals[i];
         @(negedge clk);
         if (i == 0) begin
            core_done = 1'b0;
            n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL load_done_ign got %b want 1", in_ready); end
         end
      end
      in_valid = 1'b0;
      n_tests++; if (buf_data !== 32'h44332211) begin n_fail++; $display("FAIL load_buf got %h want 44332211", buf_data); end
      n_tests++; if (changes !== 1'b1) begin n_fail++; $display("FAIL load_chg got %b want 1", changes); end
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL load_ready_drop got %b want 0", in_ready); end
      @(negedge clk);
      n_tests++; if (n_chg !== chg_base + 1) begin n_fail++; $display("FAIL load_one_pulse got %0d want %0d", n_chg - chg_base, 1); end
      @(negedge clk);
      n_tests++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL load_start_early got %b want 0", core_start); end
      core_done = 1'b1; res_data = 16'h1234;  // done in core_start cycle must be ignored
      @(negedge clk);
      n_tests++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL load_start got %b want 1", core_start); end
      core_done = 1'b0;
      @(negedge clk);
      n_tests++; if (core_start !== 1'b0) begin n_fail++; $display("FAIL start_width got %b want 0", core_start); end
      n_tests++; if (changes !== 1'b0) begin n_fail++; $display("FAIL start_done_ign got %b want 0", changes); end
   endtask

   task automatic wait_out_valid(input string name);
      int k;
      k = 0;
      while (out_valid !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL %s timeout got %b want 1", name, out_valid); end
   endtask

   task automatic test_layer_loop;
      int k;
      in_valid = 1'b1; in_data = 8'hEE;  // spurious input during RUN/DRAIN
      repeat (2) @(negedge clk);
      core_done = 1'b1; res_data = 16'hBBAA; @(negedge clk);
      core_done = 1'b0; res_data = 16'h0;
      n_tests++; if (changes !== 1'b1) begin n_fail++; $display("FAIL run1_chg got %b want 1", changes); end
      wait_out_valid("drain1");
      n_tests++; if (out_data !== 8'hAA) begin n_fail++; $display("FAIL drain1_w0 got %h want aa", out_data); end
      core_done = 1'b1; res_data = 16'h7777;  // spurious done during DRAIN
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         core_done = 1'b0;
         n_tests++; if (out_valid !== 1'b1 || out_data !== 8'hAA) begin
            n_fail++; $display("FAIL bp_hold%0d got %b/%h want 1/aa", i, out_valid, out_data); end
         n_tests++; if (changes !== 1'b0 || finished !== 1'b0) begin
            n_fail++; $display("FAIL bp_pulse%0d got %b%b want 00", i, changes, finished); end
      end
      n_tests++; if (buf_data !== 32'h44332211) begin n_fail++; $display("FAIL spur_in got %h want 44332211", buf_data); end
      in_valid = 1'b0;
      out_ready = 1'b1; @(negedge clk);
      n_tests++; if (out_data !== 8'hBB || out_valid !== 1'b1) begin
         n_fail++; $display("FAIL drain1_w1 got %b/%h want 1/bb", out_valid, out_data); end
      @(negedge clk);
      out_ready = 1'b0;
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL drain1_end got %b want 0", out_valid); end
      n_tests++; if (changes !== 1'b1 || finished !== 1'b0) begin
         n_fail++; $display("FAIL drain1_pulse got %b%b want 10", changes, finished); end
      n_tests++; if (layer_idx !== 1'b1) begin n_fail++; $display("FAIL layer1 got %b want 1", layer_idx); end
      k = 0;
      while (core_start !== 1'b1 && k < 20) begin @(negedge clk); k++; end
      n_tests++; if (core_start !== 1'b1) begin n_fail++; $display("FAIL start2 timeout got %b want 1", core_start); end
      @(negedge clk);
      core_done = 1'b1; res_data = 16'hD0C0; @(negedge clk);
      core_done = 1'b0;
      n_tests++; if (changes !== 1'b1) begin n_fail++; $display("FAIL run2_chg got %b want 1", changes); end
      out_ready = 1'b1;
      wait_out_valid("drain2");
      n_tests++; if (out_data !== 8'hC0) begin n_fail++; $display("FAIL drain2_w0 got %h want c0", out_data); end
      @(negedge clk);
      n_tests++; if (out_data !== 8'hD0) begin n_fail++; $display("FAIL drain2_w1 got %h want d0", out_data); end
      @(negedge clk);
      out_ready = 1'b0;
      n_tests++; if (finished !== 1'b1 || changes !== 1'b0) begin
         n_fail++; $display("FAIL drain2_pulse got %b%b want 01", changes, finished); end
      n_tests++; if (layer_idx !== 1'b0) begin n_fail++; $display("FAIL layer_wrap got %b want 0", layer_idx); end
      @(negedge clk);
      n_tests++; if (finished !== 1'b0) begin n_fail++; $display("FAIL fin_width got %b want 0", finished); end
      @(negedge clk);
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL ready_early got %b want 0", in_ready); end
      @(negedge clk);
      n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL ready_again got %b want 1", in_ready); end
   endtask

   task automatic test_pulse_hygiene;
      // load + (run, drain) per layer: 2*N_LAYERS changes, one finished
      n_tests++; if (n_chg - chg_base !== 4) begin n_fail++; $display("FAIL hyg_changes got %0d want 4", n_chg - chg_base); end
      n_tests++; if (n_fin - fin_base !== 1) begin n_fail++; $display("FAIL hyg_finished got %0d want 1", n_fin - fin_base); end
      n_tests++; if (n_both !== 0) begin n_fail++; $display("FAIL hyg_overlap got %0d want 0", n_both); end
      n_tests++; if (n_long !== 0) begin n_fail++; $display("FAIL hyg_width got %0d want 0", n_long); end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_data = 8'h0;
      core_done = 1'b0; res_data = 16'h0; out_ready = 1'b0;
      test_reset;
      test_reset_mid_load;
      test_load;
      test_layer_loop;
      test_pulse_hygiene;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
